// File: rtl/ps2_pkg.sv
// Shared types and bus field positions for the PS/2 mouse receiver.
package ps2_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } bit_state_t;

   // Field positions inside the 25-bit ps2_mouse bus
   localparam int MS_STROBE = 24;
   localparam int MS_Y_LSB  = 16;
   localparam int MS_X_LSB  = 8;
   localparam int MS_LBTN   = 0;
   localparam int MS_RBTN   = 1;
   localparam int MS_XSIGN  = 4;
   localparam int MS_YSIGN  = 5;
   localparam int MS_SYNC   = 3;

   // PS/2 uses odd parity: data bits plus parity bit must hold an odd number of ones
   function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
      return ^{data, par};
   endfunction

endpackage

// File: rtl/ps2_line_cond.sv
// Conditions the raw PS/2 lines: 2-FF synchronisers on both lines, a
// stability filter on the clock line and a falling-edge strobe from the
// filtered clock. The data line only needs the synchroniser.
module ps2_line_cond #(
   parameter int FILTER_LEN = 8
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clk_line_i,
   input  logic data_line_i,
   output logic data_sync_o,
   output logic fall_o
);

   localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

   logic          clk_meta_q, clk_sync_q;
   logic          data_meta_q, data_sync_q;
   logic          filt_q, filt_prev_q;
   logic [CW-1:0] cnt_q;

   // Two-stage synchronisers; idle-high reset so reset release is not seen as an edge
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         clk_meta_q  <= 1'b1;
         clk_sync_q  <= 1'b1;
         data_meta_q <= 1'b1;
         data_sync_q <= 1'b1;
      end else begin
         clk_meta_q  <= clk_line_i;
         clk_sync_q  <= clk_meta_q;
         data_meta_q <= data_line_i;
         data_sync_q <= data_meta_q;
      end
   end

   // Accept a new clock level only after it has differed from the filtered level for FILTER_LEN cycles
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         filt_q      <= 1'b1;
         filt_prev_q <= 1'b1;
         cnt_q       <= '0;
      end else begin
         filt_prev_q <= filt_q;
         if (clk_sync_q == filt_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CNT_LAST) begin
            filt_q <= clk_sync_q;
            cnt_q  <= '0;
         end else begin
            cnt_q <= cnt_q + CW'(1);
         end
      end
   end

   assign data_sync_o = data_sync_q;
   assign fall_o      = filt_prev_q & ~filt_q;

endmodule

// File: rtl/ps2_mouse_rx.sv
// PS/2 mouse receiver: frames bytes off the PS/2 lines and assembles
// 3-byte stream packets onto a toggle-strobe bus.
//
//  state  | meaning
//  IDLE   | waiting for a start bit (data low on a clock fall)
//  DATA   | shifting in 8 data bits, LSB first
//  PARITY | sampling the odd-parity bit
//  STOP   | sampling the stop bit, then accept or reject the byte
module ps2_mouse_rx
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN = 8,
   parameter int TIMEOUT    = 100000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   output logic [24:0] ps2_mouse,
   output logic        err_parity,
   output logic        err_frame
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
   localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT);

   logic          fall, data_s;
   bit_state_t    state_q;
   logic [2:0]    bit_cnt_q;
   logic [7:0]    shift_q, shift_d;
   logic          par_ok_q;
   logic [1:0]    idx_q;
   logic [7:0]    byte0_q, byte1_q;
   logic [24:0]   mouse_q;
   logic          err_par_q, err_frm_q;
   logic [TW-1:0] tmo_q;
   logic          busy;

   ps2_line_cond #(.FILTER_LEN(FILTER_LEN)) u_cond (
      .clk         (clk),
      .reset_n     (reset_n),
      .clk_line_i  (ps2_clk),
      .data_line_i (ps2_data),
      .data_sync_o (data_s),
      .fall_o      (fall)
   );

   assign shift_d = {data_s, shift_q[7:1]};
   // Timer runs whenever a frame or a packet is partially received
   assign busy    = (state_q != IDLE) || (idx_q != 2'd0);

   // Bit framing, packet assembly and timeout; a clock fall always beats the timeout
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         par_ok_q  <= 1'b0;
         idx_q     <= '0;
         byte0_q   <= '0;
         byte1_q   <= '0;
         mouse_q   <= '0;
         err_par_q <= 1'b0;
         err_frm_q <= 1'b0;
         tmo_q     <= '0;
      end else begin
         err_par_q <= 1'b0;
         err_frm_q <= 1'b0;
         if (fall) begin
            tmo_q <= '0;
            case (state_q)
               IDLE: begin
                  if (!data_s) begin
                     state_q   <= DATA;
                     bit_cnt_q <= '0;
                  end else begin
                     err_frm_q <= 1'b1;
                  end
               end
               DATA: begin
                  shift_q   <= shift_d;
                  bit_cnt_q <= bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) state_q <= PARITY;
               end
               PARITY: begin
                  par_ok_q <= odd_parity_ok(shift_q, data_s);
                  state_q  <= STOP;
               end
               STOP: begin
                  state_q <= IDLE;
                  if (!data_s) begin
                     err_frm_q <= 1'b1;
                     idx_q     <= '0;
                  end else if (!par_ok_q) begin
                     err_par_q <= 1'b1;
                     idx_q     <= '0;
                  end else begin
                     case (idx_q)
                        2'd0: begin
                           if (shift_q[MS_SYNC]) begin
                              byte0_q <= shift_q;
                              idx_q   <= 2'd1;
                           end else begin
                              err_frm_q <= 1'b1;
                           end
                        end
                        2'd1: begin
                           byte1_q <= shift_q;
                           idx_q   <= 2'd2;
                        end
                        default: begin
                           mouse_q[MS_Y_LSB +: 8] <= shift_q;
                           mouse_q[MS_X_LSB +: 8] <= byte1_q;
                           mouse_q[7:0]           <= byte0_q;
                           mouse_q[MS_STROBE]     <= ~mouse_q[MS_STROBE];
                           idx_q                  <= '0;
                        end
                     endcase
                  end
               end
               default: state_q <= IDLE;
            endcase
         end else if (busy) begin
            if (tmo_q == TMO_LAST) begin
               tmo_q     <= TMO_MAX;
               state_q   <= IDLE;
               idx_q     <= '0;
               err_frm_q <= 1'b1;
            end else if (tmo_q != TMO_MAX) begin
               tmo_q <= tmo_q + TW'(1);
            end
         end else begin
            tmo_q <= '0;
         end
      end
   end

   assign ps2_mouse  = mouse_q;
   assign err_parity = err_par_q;
   assign err_frame  = err_frm_q;

endmodule

// File: tb/tb_ps2_mouse_rx.sv
// Bench for ps2_mouse_rx: drives PS/2 frames, predicts packets and error
// pulses from the byte-level protocol rules, and compares against a monitor.
module tb_ps2_mouse_rx;
   import ps2_pkg::*;

   localparam int H   = 20;    // PS/2 clock half period in clk cycles
   localparam int TMO = 1000;
   localparam int FL  = 8;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        ps2_clk = 1'b1;
   logic        ps2_data = 1'b1;
   logic [24:0] ps2_mouse;
   logic        err_parity, err_frame;

   int n_chk = 0;
   int n_err = 0;

   // reference model state
   int          m_idx = 0;
   logic [7:0]  m_buf [0:2];
   logic [23:0] exp_q[$];
   logic [23:0] obs_q[$];
   int          exp_epar = 0, exp_efr = 0;
   int          obs_epar = 0, obs_efr = 0;

   logic        prev_strobe = 1'b0;
   logic [23:0] last_low = '0;

   ps2_mouse_rx #(.FILTER_LEN(FL), .TIMEOUT(TMO)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .ps2_mouse  (ps2_mouse),
      .err_parity (err_parity),
      .err_frame  (err_frame)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // monitor: capture each strobe toggle and error pulse
   always @(negedge clk) begin
      if (!reset_n) begin
         prev_strobe = 1'b0;
         last_low    = '0;
      end else begin
         logic tog;
         tog = (ps2_mouse[24] !== prev_strobe);
         if (tog) obs_q.push_back(ps2_mouse[23:0]);
         if (ps2_mouse[23:0] !== last_low) check("data_only_with_toggle", 32'(tog), 32'd1);
         if (err_parity) begin
            obs_epar++;
            check("err_par_vs_toggle", 32'(tog), 32'd0);
         end
         if (err_frame) begin
            obs_efr++;
            check("err_frm_vs_toggle", 32'(tog), 32'd0);
         end
         prev_strobe = ps2_mouse[24];
         last_low    = ps2_mouse[23:0];
      end
   end

   // byte-level protocol model
   task automatic model_byte(input logic [7:0] b, input bit pb, input bit sb);
      if (sb) begin
         exp_efr++;
         m_idx = 0;
      end else if (pb) begin
         exp_epar++;
         m_idx = 0;
      end else if (m_idx == 0 && !b[3]) begin
         exp_efr++;
      end else begin
         m_buf[m_idx] = b;
         m_idx++;
         if (m_idx == 3) begin
            exp_q.push_back({m_buf[2], m_buf[1], m_buf[0]});
            m_idx = 0;
         end
      end
   endtask

   task automatic send_bit(input logic v);
      @(negedge clk) ps2_data = v;
      repeat (H) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (H) @(negedge clk);
      ps2_clk = 1'b1;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit pb = 0, input bit sb = 0);
      logic [10:0] fr;
      fr = {~sb, (~^b) ^ pb, b, 1'b0};
      for (int i = 0; i < 11; i++) send_bit(fr[i]);
      @(negedge clk) ps2_data = 1'b1;
      repeat (2 * H) @(negedge clk);
      model_byte(b, pb, sb);
   endtask

   task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
      send_byte(b0);
      send_byte(b1);
      send_byte(b2);
   endtask

   // a partial packet left in the model must end in a receiver timeout
   task automatic flush_timeout();
      if (m_idx != 0) begin
         exp_efr++;
         m_idx = 0;
         repeat (TMO + 60) @(negedge clk);
      end
   endtask

   task automatic compare(input string tag);
      repeat (40) @(negedge clk);
      check({tag, "_npkt"}, obs_q.size(), exp_q.size());
      while (exp_q.size() > 0 && obs_q.size() > 0)
         check({tag, "_pkt"}, obs_q.pop_front(), exp_q.pop_front());
      check({tag, "_eparity"}, obs_epar, exp_epar);
      check({tag, "_eframe"}, obs_efr, exp_efr);
      exp_q.delete();
      obs_q.delete();
      exp_epar = 0; exp_efr = 0; obs_epar = 0; obs_efr = 0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      n_err++;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [7:0] b;
      int sel, nb;

      // reset
      repeat (3) @(negedge clk);
      check("rst_mouse", ps2_mouse, 0);
      check("rst_eflags", {err_parity, err_frame}, 0);
      reset_n = 1'b1;
      repeat (20) @(negedge clk);
      check("post_rst_mouse", ps2_mouse, 0);

      // single valid packet
      send_pkt(8'h09, 8'h05, 8'hFB);
      check("pkt1_full", ps2_mouse, 25'h1FB0509);
      check("pkt1_lbtn", ps2_mouse[MS_LBTN], 1);
      check("pkt1_rbtn", ps2_mouse[MS_RBTN], 0);
      check("pkt1_signs", {ps2_mouse[MS_YSIGN], ps2_mouse[MS_XSIGN]}, 0);
      check("pkt1_x", ps2_mouse[MS_X_LSB +: 8], 8'h05);
      check("pkt1_y", ps2_mouse[MS_Y_LSB +: 8], 8'hFB);
      compare("pkt1");

      // back-to-back packets
      send_pkt(8'h08, 8'h00, 8'h00);
      check("b2b_mid", ps2_mouse[23:0], 24'h000008);
      send_pkt(8'h3A, 8'h80, 8'h7F);
      check("b2b_final", ps2_mouse, 25'h17F803A);
      compare("b2b");

      // parity error on byte 1 drops the packet, next packet is clean
      send_byte(8'h09);
      send_byte(8'h05, 1, 0);
      check("par_no_update", ps2_mouse, 25'h17F803A);
      send_pkt(8'h0A, 8'h01, 8'h02);
      check("par_next", ps2_mouse[23:0], 24'h02010A);
      compare("parity");

      // sync bit failure
      send_byte(8'h01);
      send_pkt(8'h09, 8'h10, 8'h20);
      check("sync_next", ps2_mouse[23:0], 24'h201009);
      compare("sync");

      // bad stop bit mid-packet
      send_byte(8'h0C);
      send_byte(8'h33, 0, 1);
      send_pkt(8'h18, 8'h44, 8'h55);
      compare("stop");

      // bad start bit: a lone clock fall with data high
      send_bit(1'b1);
      exp_efr++;
      repeat (2 * H) @(negedge clk);
      compare("start");

      // timeout mid-frame
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'($urandom));
      n = 0;
      while (!err_frame && n < 3 * TMO) begin
         @(negedge clk);
         n++;
      end
      check("tmo_seen", err_frame, 1);
      check("tmo_window", 32'((n >= TMO - H - 5) && (n <= TMO + H)), 1);
      exp_efr++;
      ps2_data = 1'b1;
      send_pkt(8'h09, 8'h05, 8'hFB);
      compare("timeout");

      // short clock glitches must not shift bits
      ps2_data = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk) ps2_clk = 1'b0;
         repeat (3) @(negedge clk);
         ps2_clk = 1'b1;
         repeat (15) @(negedge clk);
      end
      ps2_data = 1'b1;
      repeat (TMO + 60) @(negedge clk);
      send_pkt(8'h0A, 8'h01, 8'h02);
      compare("glitch");

      // asynchronous reset mid-byte
      check("pre_rst_nonzero", 32'(ps2_mouse != 0), 1);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b1);
      @(negedge clk);
      #1 reset_n = 1'b0;
      #1 check("rst_async_mouse", ps2_mouse, 0);
      check("rst_async_err", {err_parity, err_frame}, 0);
      m_idx = 0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (10) @(negedge clk);
      send_pkt(8'h08, 8'h7F, 8'h81);
      check("post_rst_strobe", ps2_mouse[24], 1);
      compare("rst_mid");

      // randomized byte streams with occasional parity/stop errors
      for (int r = 0; r < 6; r++) begin
         nb = $urandom_range(3, 7);
         for (int k = 0; k < nb; k++) begin
            b = 8'($urandom);
            if ($urandom_range(0, 9) < 7) b[3] = 1'b1;
            sel = $urandom_range(0, 9);
            send_byte(b, sel == 0, sel == 1);
         end
         flush_timeout();
         compare("rnd");
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
